opr_sequencer: RTL

Self-timed, parametrised microsequencer for PDP-8 operate (opcode 7) instructions. It replaces externally supplied phase clocks with an internal state machine: the instruction word is captured on `start`, and each required micro-step runs in one clock cycle. Covered: group 1 (including two-pass double rotates), group 2 skips, and all 16 group 3 CLA/MQA/SCA/MQL combinations (including the EAE SCA path). It sits between the instruction decoder and the AC/MQ/LINK/PC datapath and drives their bus enables and clock enables.

---
 rtl/opr_sequencer.sv | 70 +++++++
 1 files changed

// File: rtl/opr_sequencer.sv
// opr_sequencer: self-timed microsequencer for PDP-8 operate instructions (groups 1, 2 and 3).
module opr_sequencer #(
  parameter bit EAE  = 1'b1,
  parameter bit ROT2 = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [8:0] ir,
  input  logic       doSkip,
  output logic       rot2ac,
  output logic       cla,
  output logic       mq2orbus,
  output logic       mq_tmpOE,
  output logic       sc2orbus,
  output logic       mq_tmpLatch,
  output logic       ac_ck,
  output logic       link_ck,
  output logic       mq_ck,
  output logic       pc_ck,
  output logic       pass2,
  output logic       busy,
  output logic       done
);
  typedef enum logic [3:0] {IDLE, G1A, G1B, G2A, G2B, G3CLA, G3MQL, G3OR, DONE} state_t;
  state_t state, next;
  // ir[8] and ir[0] only steer the group choice at accept time, so they are not held
  logic [7:1] ir_q;
  logic sca_q, or_q, or_i;
  assign sca_q = EAE & ir_q[5];
  assign or_q  = ir_q[6] | sca_q | ir_q[4];
  assign or_i  = ir[6] | (EAE & ir[5]) | ir[4];
  always_comb begin
    next = IDLE;
    case (state)
      IDLE:    next = !start ? IDLE : !ir[8] ? G1A : !ir[0] ? G2A :
                      ir[7] ? G3CLA : ir[4] ? G3MQL : or_i ? G3OR : DONE;
      G1A:     next = (ROT2 && ir_q[1] && (ir_q[3] || ir_q[2])) ? G1B : DONE;
      G1B:     next = DONE;
      G2A:     next = G2B;
      G2B:     next = DONE;
      G3CLA:   next = ir_q[4] ? G3MQL : or_q ? G3OR : DONE;
      G3MQL:   next = G3OR;
      G3OR:    next = DONE;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ir_q  <= '0;
    end else begin
      state <= next;
      if (state == IDLE && start) ir_q <= ir[7:1];
    end
  end
  assign rot2ac      = state inside {G1A, G1B, G2A, G2B, G3CLA, G3MQL, G3OR};
  assign cla         = (state == G3CLA) | ((state == G3OR) & ir_q[4]);
  assign mq2orbus    = (state == G3OR) & ir_q[6] & !ir_q[4];
  assign mq_tmpOE    = (state == G3OR) & ir_q[6] & ir_q[4];
  assign sc2orbus    = (state == G3OR) & sca_q;
  assign mq_tmpLatch = state == G3MQL;
  assign mq_ck       = state == G3MQL;
  assign ac_ck       = state inside {G1A, G1B, G2B, G3CLA, G3OR};
  assign link_ck     = state inside {G1A, G1B};
  assign pc_ck       = (state == G2A) & doSkip;
  assign pass2       = state == G1B;
  assign busy        = state != IDLE;
  assign done        = state == DONE;
endmodule
